// File: rtl/axisr_rr_mux_pkg.sv
// ---------------------------------------------------------------------------------------------
// axisr_rr_mux_pkg: types local to the round-robin packet mux.
//   mux_state_e : arbitration FSM states (idle/arbitrating vs. locked onto a packet).
//   MAX_CHAN    : largest supported channel count.
// ---------------------------------------------------------------------------------------------
package axisr_rr_mux_pkg;

    localparam int unsigned MAX_CHAN = 16;

    typedef enum logic {
        StIdle,
        StLocked
    } mux_state_e;

endpackage

// File: rtl/roceTypes_pkg.sv
// ---------------------------------------------------------------------------------------------
// roceTypes: shared widths and helpers for the RoCE datapath.
//   AXI_DATA_BITS : default AXI4-stream tdata width.
//   PID_BITS      : process/QP identifier width, carried on tid.
//   clog2_min1()  : ceil(log2(n)) but never below 1, so index vectors stay non-empty.
// ---------------------------------------------------------------------------------------------
package roceTypes;

    localparam int unsigned AXI_DATA_BITS = 512;
    localparam int unsigned PID_BITS      = 6;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = (n < 2) ? 1 : int'($clog2(n));
        return r;
    endfunction

endpackage

// File: rtl/axisr_rr_mux_reg.sv
// ---------------------------------------------------------------------------------------------
// axisr_reg_slice: 2-entry (main + skid) AXI4-stream register slice.
// Fully registered in both directions: m_tvalid comes from the main register and s_tready
// from a registered "skid empty" flag, so neither depends combinationally on m_tready.
// Ports:
//   aclk, areset        clock, asynchronous active-high reset (clears both entries)
//   s_t*                upstream beat (tdata/tkeep/tid/tlast) with tvalid/tready
//   m_t*                downstream beat with tvalid/tready; fields held stable while stalled
// ---------------------------------------------------------------------------------------------
module axisr_reg_slice #(
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned ID_BITS   = 6
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [DATA_BITS-1:0]   s_tdata,
    input  logic [DATA_BITS/8-1:0] s_tkeep,
    input  logic [ID_BITS-1:0]     s_tid,
    input  logic                   s_tlast,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [DATA_BITS-1:0]   m_tdata,
    output logic [DATA_BITS/8-1:0] m_tkeep,
    output logic [ID_BITS-1:0]     m_tid,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready
);

    localparam int unsigned BEAT_W = DATA_BITS + DATA_BITS / 8 + ID_BITS + 1;

    logic [BEAT_W-1:0] r_main;
    logic [BEAT_W-1:0] r_skid;
    logic              r_main_vld;
    logic              r_skid_vld;
    logic              r_can_accept;

    logic [BEAT_W-1:0] w_main_nxt;
    logic [BEAT_W-1:0] w_skid_nxt;
    logic              w_main_vld_nxt;
    logic              w_skid_vld_nxt;
    logic [BEAT_W-1:0] w_in_beat;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_in_beat  = {s_tdata, s_tkeep, s_tid, s_tlast};
    assign w_in_fire  = s_tvalid && r_can_accept;
    assign w_out_fire = r_main_vld && m_tready;

    always_comb begin
        w_main_nxt     = r_main;
        w_skid_nxt     = r_skid;
        w_main_vld_nxt = r_main_vld;
        w_skid_vld_nxt = r_skid_vld;
        if (r_skid_vld) begin
            // Upstream is already stalled; only a drain can make progress.
            if (w_out_fire) begin
                w_main_nxt     = r_skid;
                w_skid_vld_nxt = 1'b0;
            end
        end else if (w_in_fire) begin
            if (!r_main_vld || w_out_fire) begin
                w_main_nxt     = w_in_beat;
                w_main_vld_nxt = 1'b1;
            end else begin
                // Main is stalled: park the beat so s_tready can drop a cycle late.
                w_skid_nxt     = w_in_beat;
                w_skid_vld_nxt = 1'b1;
            end
        end else if (w_out_fire) begin
            w_main_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_vld   <= 1'b0;
            r_skid_vld   <= 1'b0;
            r_can_accept <= 1'b0;
        end else begin
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
            r_main_vld   <= w_main_vld_nxt;
            r_skid_vld   <= w_skid_vld_nxt;
            r_can_accept <= !w_skid_vld_nxt;
        end
    end

    assign s_tready                           = r_can_accept;
    assign m_tvalid                           = r_main_vld;
    assign {m_tdata, m_tkeep, m_tid, m_tlast} = r_main;

endmodule

// File: rtl/axisr_rr_mux.sv
// ---------------------------------------------------------------------------------------------
// axisr_rr_mux: N-to-1 packet-atomic round-robin multiplexer for routed AXI4-stream traffic.
// One IDLE cycle arbitrates (scan from rr_ptr), then LOCKED forwards the granted channel
// until its tlast, after which rr_ptr moves past the served channel. The output passes
// through axisr_reg_slice.
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   s_tdata/tkeep/tid     flattened per-channel fields, channel i in slice i
//   s_tlast/tvalid/tready per-channel handshake (ready only for the granted channel)
//   m_t*                  merged output stream
//   grant_idx, busy       granted channel (valid while busy) and LOCKED indicator
// TID_MODE: 0 forwards the source tid, 1 replaces it with the granted channel index.
// ---------------------------------------------------------------------------------------------
module axisr_rr_mux
    import roceTypes::*;
    import axisr_rr_mux_pkg::*;
#(
    parameter int unsigned N_CHAN    = 4,
    parameter int unsigned DATA_BITS = AXI_DATA_BITS,
    parameter int unsigned ID_BITS   = PID_BITS,
    parameter int unsigned TID_MODE  = 0
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [N_CHAN*DATA_BITS-1:0]     s_tdata,
    input  logic [N_CHAN*DATA_BITS/8-1:0]   s_tkeep,
    input  logic [N_CHAN*ID_BITS-1:0]       s_tid,
    input  logic [N_CHAN-1:0]               s_tlast,
    input  logic [N_CHAN-1:0]               s_tvalid,
    output logic [N_CHAN-1:0]               s_tready,
    output logic [DATA_BITS-1:0]            m_tdata,
    output logic [DATA_BITS/8-1:0]          m_tkeep,
    output logic [ID_BITS-1:0]              m_tid,
    output logic                            m_tlast,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [clog2_min1(N_CHAN)-1:0]   grant_idx,
    output logic                            busy
);

    localparam int unsigned IDX_W     = clog2_min1(N_CHAN);
    localparam int unsigned KEEP_BITS = DATA_BITS / 8;
    localparam logic [IDX_W:0] N_CHAN_W = (IDX_W + 1)'(N_CHAN);
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(N_CHAN - 1);

    if (N_CHAN < 1 || N_CHAN > MAX_CHAN) begin : g_bad_nchan
        $error("axisr_rr_mux: N_CHAN must be in 1..16");
    end
    if (TID_MODE == 1 && ID_BITS < $clog2(N_CHAN)) begin : g_bad_tid
        $error("axisr_rr_mux: TID_MODE=1 needs ID_BITS >= clog2(N_CHAN)");
    end

    mux_state_e       r_state;
    mux_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_ptr_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_grant_nxt;

    logic             w_req_found;
    logic [IDX_W-1:0] w_req_idx;
    logic [IDX_W:0]   w_cand;

    logic [DATA_BITS-1:0] w_sel_tdata;
    logic [KEEP_BITS-1:0] w_sel_tkeep;
    logic [ID_BITS-1:0]   w_sel_tid;
    logic                 w_sel_tlast;
    logic                 w_sel_tvalid;
    logic [ID_BITS-1:0]   w_out_tid;
    logic                 w_slice_tvalid;
    logic                 w_slice_ready;
    logic                 w_xfer_last;

    // Rotating priority scan starting at rr_ptr; rr_ptr + k stays below 2*N_CHAN.
    always_comb begin
        w_req_found = 1'b0;
        w_req_idx   = '0;
        w_cand      = '0;
        for (int unsigned k = 0; k < N_CHAN; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
            if (w_cand >= N_CHAN_W) begin
                w_cand = w_cand - N_CHAN_W;
            end
            if (!w_req_found && s_tvalid[w_cand[IDX_W-1:0]]) begin
                w_req_found = 1'b1;
                w_req_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_tdata  = '0;
        w_sel_tkeep  = '0;
        w_sel_tid    = '0;
        w_sel_tlast  = 1'b0;
        w_sel_tvalid = 1'b0;
        for (int unsigned c = 0; c < N_CHAN; c++) begin
            if (r_grant == IDX_W'(c)) begin
                w_sel_tdata  = s_tdata[c*DATA_BITS +: DATA_BITS];
                w_sel_tkeep  = s_tkeep[c*KEEP_BITS +: KEEP_BITS];
                w_sel_tid    = s_tid[c*ID_BITS +: ID_BITS];
                w_sel_tlast  = s_tlast[c];
                w_sel_tvalid = s_tvalid[c];
            end
        end
    end

    always_comb begin
        s_tready = '0;
        for (int unsigned c = 0; c < N_CHAN; c++) begin
            if (r_state == StLocked && r_grant == IDX_W'(c)) begin
                s_tready[c] = w_slice_ready;
            end
        end
    end

    assign w_slice_tvalid = (r_state == StLocked) && w_sel_tvalid;
    assign w_xfer_last    = w_slice_tvalid && w_slice_ready && w_sel_tlast;
    assign w_out_tid      = (TID_MODE == 1) ? ID_BITS'(r_grant) : w_sel_tid;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        unique case (r_state)
            StIdle: begin
                if (w_req_found) begin
                    w_grant_nxt = w_req_idx;
                    w_state_nxt = StLocked;
                end
            end
            StLocked: begin
                // Lock holds across gaps in s_tvalid; only the granted tlast releases it.
                if (w_xfer_last) begin
                    w_state_nxt  = StIdle;
                    w_rr_ptr_nxt = (r_grant == LAST_CH) ? '0 : r_grant + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state  <= StIdle;
            r_rr_ptr <= '0;
            r_grant  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_grant  <= w_grant_nxt;
        end
    end

    assign grant_idx = r_grant;
    assign busy      = (r_state == StLocked);

    axisr_reg_slice #(
        .DATA_BITS (DATA_BITS),
        .ID_BITS   (ID_BITS)
    ) u_slice (
        .aclk     (aclk),
        .areset   (areset),
        .s_tdata  (w_sel_tdata),
        .s_tkeep  (w_sel_tkeep),
        .s_tid    (w_out_tid),
        .s_tlast  (w_sel_tlast),
        .s_tvalid (w_slice_tvalid),
        .s_tready (w_slice_ready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tid    (m_tid),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

endmodule

// File: tb/tb_axisr_rr_mux.sv
// ---------------------------------------------------------------------------------------------
// tb_axisr_rr_mux: directed bench for axisr_rr_mux (N_CHAN=4, 16-bit data, 8-bit tid).
// Two instances share all inputs: u_dut forwards tid, u_dut_tid stamps the channel index.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------------------------
module tb_axisr_rr_mux;

    logic        aclk;
    logic        areset;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic [31:0] s_tid;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tvalid;
    logic        m_tready;

    logic [3:0]  s_tready;
    logic [15:0] m_tdata;
    logic [1:0]  m_tkeep;
    logic [7:0]  m_tid;
    logic        m_tlast;
    logic        m_tvalid;
    logic [1:0]  grant_idx;
    logic        busy;

    logic [3:0]  t_s_tready;
    logic [15:0] t_m_tdata;
    logic [1:0]  t_m_tkeep;
    logic [7:0]  t_m_tid;
    logic        t_m_tlast;
    logic        t_m_tvalid;
    logic [1:0]  t_grant_idx;
    logic        t_busy;

    int n_assert;
    int n_fail;

    axisr_rr_mux #(
        .N_CHAN    (4),
        .DATA_BITS (16),
        .ID_BITS   (8),
        .TID_MODE  (0)
    ) u_dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tid     (s_tid),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tid     (m_tid),
        .m_tlast   (m_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    axisr_rr_mux #(
        .N_CHAN    (4),
        .DATA_BITS (16),
        .ID_BITS   (8),
        .TID_MODE  (1)
    ) u_dut_tid (
        .aclk      (aclk),
        .areset    (areset),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tid     (s_tid),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (t_s_tready),
        .m_tdata   (t_m_tdata),
        .m_tkeep   (t_m_tkeep),
        .m_tid     (t_m_tid),
        .m_tlast   (t_m_tlast),
        .m_tvalid  (t_m_tvalid),
        .m_tready  (m_tready),
        .grant_idx (t_grant_idx),
        .busy      (t_busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ch, input logic v, input logic [15:0] d,
                         input logic l, input logic [7:0] id, input logic [1:0] k);
        s_tvalid[ch]          = v;
        s_tdata[ch*16 +: 16]  = d;
        s_tkeep[ch*2 +: 2]    = k;
        s_tid[ch*8 +: 8]      = id;
        s_tlast[ch]           = l;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    int          k_sent;
    int          k_rcv;
    logic        fire_in;
    logic        fire_out;
    logic        hold;
    logic [15:0] prev_data;
    logic        prev_last;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        areset   = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tid    = '0;
        s_tlast  = '0;
        s_tvalid = '0;
        m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // Reset state
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", 32'(m_tdata), 0);
        chk("rst_m_tkeep", 32'(m_tkeep), 0);
        chk("rst_m_tid", 32'(m_tid), 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_idx), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_t_m_tvalid", 32'(t_m_tvalid), 0);
        areset = 1'b0;
        step();
        chk("idle_s_tready", 32'(s_tready), 0);

        // Channels 0 and 2 contend with rr_ptr=0: ch0 packet, bubble, ch2 packet
        drive(2'd0, 1'b1, 16'h0B01, 1'b0, 8'h10, 2'b11);
        drive(2'd2, 1'b1, 16'h2B01, 1'b0, 8'h12, 2'b11);
        step();
        chk("t2_grant0", 32'(grant_idx), 0);
        chk("t2_busy", 32'(busy), 1);
        chk("t2_rdy0", 32'(s_tready), 'b0001);
        chk("t2_arb_v", 32'(m_tvalid), 0);
        step();
        chk("t2_v0", 32'(m_tvalid), 1);
        chk("t2_d0", 32'(m_tdata), 'h0B01);
        chk("t2_id0", 32'(m_tid), 'h10);
        chk("t2_l0", 32'(m_tlast), 0);
        drive(2'd0, 1'b1, 16'h0B02, 1'b1, 8'h10, 2'b11);
        step();
        chk("t2_d1", 32'(m_tdata), 'h0B02);
        chk("t2_l1", 32'(m_tlast), 1);
        chk("t2_idle_busy", 32'(busy), 0);
        chk("t2_idle_rdy", 32'(s_tready), 0);
        drive(2'd0, 1'b0, 16'h0, 1'b0, 8'h0, 2'b00);
        step();
        chk("t2_bubble", 32'(m_tvalid), 0);
        chk("t2_grant2", 32'(grant_idx), 2);
        chk("t2_rdy2", 32'(s_tready), 'b0100);
        step();
        chk("t2_d2", 32'(m_tdata), 'h2B01);
        chk("t2_id2", 32'(m_tid), 'h12);
        chk("t2_l2", 32'(m_tlast), 0);
        drive(2'd2, 1'b1, 16'h2B02, 1'b1, 8'h12, 2'b11);
        step();
        chk("t2_d3", 32'(m_tdata), 'h2B02);
        chk("t2_l3", 32'(m_tlast), 1);
        drive(2'd2, 1'b0, 16'h0, 1'b0, 8'h0, 2'b00);
        step();
        chk("t2_end_v", 32'(m_tvalid), 0);
        chk("t2_end_busy", 32'(busy), 0);

        // rr_ptr=3: ch3 beats ch0; tid stamping; just-served ch3 loses to waiting ch0
        drive(2'd3, 1'b1, 16'h3C01, 1'b0, 8'h1F, 2'b11);
        drive(2'd0, 1'b1, 16'h0D01, 1'b1, 8'h20, 2'b01);
        step();
        chk("t3_grant3", 32'(grant_idx), 3);
        chk("t3_rdy3", 32'(s_tready), 'b1000);
        step();
        chk("t3_d0", 32'(m_tdata), 'h3C01);
        chk("t3_tid_pass0", 32'(m_tid), 'h1F);
        chk("t3_tid_stamp0", 32'(t_m_tid), 3);
        drive(2'd3, 1'b1, 16'h3C02, 1'b1, 8'h1F, 2'b11);
        step();
        chk("t3_d1", 32'(m_tdata), 'h3C02);
        chk("t3_l1", 32'(m_tlast), 1);
        chk("t3_tid_stamp1", 32'(t_m_tid), 3);
        drive(2'd3, 1'b1, 16'h3C03, 1'b1, 8'h1F, 2'b11);
        step();
        chk("t3_grant_fair", 32'(grant_idx), 0);
        chk("t3_bubble", 32'(m_tvalid), 0);
        step();
        chk("t3_single_d", 32'(m_tdata), 'h0D01);
        chk("t3_single_keep", 32'(m_tkeep), 'b01);
        chk("t3_single_l", 32'(m_tlast), 1);
        chk("t3_single_busy", 32'(busy), 0);
        chk("t3_tid_stamp_ch0", 32'(t_m_tid), 0);
        drive(2'd0, 1'b0, 16'h0, 1'b0, 8'h0, 2'b00);
        step();
        chk("t3_grant3b", 32'(grant_idx), 3);
        chk("t3_bubble2", 32'(m_tvalid), 0);
        step();
        chk("t3_d3", 32'(m_tdata), 'h3C03);
        chk("t3_tid_stamp3", 32'(t_m_tid), 3);
        chk("t3_tid_pass3", 32'(m_tid), 'h1F);
        drive(2'd3, 1'b0, 16'h0, 1'b0, 8'h0, 2'b00);
        step();
        chk("t3_end_busy", 32'(busy), 0);

        // Channel 1, 3-beat packet, latency 2 cycles from valid
        drive(2'd1, 1'b1, 16'h00A1, 1'b0, 8'h05, 2'b11);
        step();
        chk("t1_grant", 32'(grant_idx), 1);
        chk("t1_rdy", 32'(s_tready), 'b0010);
        chk("t1_arb_v", 32'(m_tvalid), 0);
        step();
        chk("t1_v0", 32'(m_tvalid), 1);
        chk("t1_d0", 32'(m_tdata), 'hA1);
        chk("t1_id0", 32'(m_tid), 5);
        drive(2'd1, 1'b1, 16'h00A2, 1'b0, 8'h05, 2'b11);
        step();
        chk("t1_d1", 32'(m_tdata), 'hA2);
        chk("t1_id1", 32'(m_tid), 5);
        chk("t1_l1", 32'(m_tlast), 0);
        drive(2'd1, 1'b1, 16'h00A3, 1'b1, 8'h05, 2'b01);
        step();
        chk("t1_d2", 32'(m_tdata), 'hA3);
        chk("t1_l2", 32'(m_tlast), 1);
        chk("t1_keep2", 32'(m_tkeep), 'b01);
        chk("t1_busy_fall", 32'(busy), 0);
        drive(2'd1, 1'b0, 16'h0, 1'b0, 8'h0, 2'b00);
        step();
        chk("t1_end_v", 32'(m_tvalid), 0);

        // 8-beat packet on ch2 under m_tready pattern 1,0,0,1,0,0,...
        k_sent = 0;
        k_rcv  = 0;
        drive(2'd2, 1'b1, 16'h4400, 1'b0, 8'h44, 2'b11);
        for (int cyc = 0; cyc < 80 && k_rcv < 8; cyc++) begin
            m_tready = (cyc % 3 == 0);
            fire_in  = s_tvalid[2] && s_tready[2];
            fire_out = m_tvalid && m_tready;
            hold     = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_last = m_tlast;
            if (fire_out) begin
                chk("t4_data", 32'(m_tdata), 32'h4400 + 32'(k_rcv));
                chk("t4_last", 32'(m_tlast), (k_rcv == 7) ? 1 : 0);
                k_rcv++;
            end
            step();
            if (hold) begin
                chk("t4_hold_v", 32'(m_tvalid), 1);
                chk("t4_hold_d", 32'(m_tdata), 32'(prev_data));
                chk("t4_hold_l", 32'(m_tlast), 32'(prev_last));
            end
            if (fire_in) begin
                k_sent++;
                if (k_sent < 8) begin
                    drive(2'd2, 1'b1, 16'h4400 + 16'(k_sent), (k_sent == 7), 8'h44, 2'b11);
                end else begin
                    drive(2'd2, 1'b0, 16'h0, 1'b0, 8'h0, 2'b00);
                end
            end
        end
        chk("t4_count", 32'(k_rcv), 8);
        m_tready = 1'b1;
        drive(2'd2, 1'b0, 16'h0, 1'b0, 8'h0, 2'b00);
        step();
        step();
        chk("t4_drain_v", 32'(m_tvalid), 0);
        chk("t4_drain_busy", 32'(busy), 0);

        // ch1 stalls 5 cycles mid-packet while ch0 waits
        drive(2'd1, 1'b1, 16'h5101, 1'b0, 8'h51, 2'b11);
        step();
        chk("t5_grant1", 32'(grant_idx), 1);
        drive(2'd0, 1'b1, 16'h0E01, 1'b1, 8'h0E, 2'b11);
        step();
        chk("t5_d0", 32'(m_tdata), 'h5101);
        drive(2'd1, 1'b0, 16'h5102, 1'b0, 8'h51, 2'b11);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_gap_v", 32'(m_tvalid), 0);
            chk("t5_gap_busy", 32'(busy), 1);
            chk("t5_gap_grant", 32'(grant_idx), 1);
        end
        drive(2'd1, 1'b1, 16'h5102, 1'b1, 8'h51, 2'b11);
        step();
        chk("t5_d1", 32'(m_tdata), 'h5102);
        chk("t5_l1", 32'(m_tlast), 1);
        drive(2'd1, 1'b0, 16'h0, 1'b0, 8'h0, 2'b00);
        step();
        chk("t5_grant0", 32'(grant_idx), 0);
        chk("t5_bubble", 32'(m_tvalid), 0);
        step();
        chk("t5_d2", 32'(m_tdata), 'h0E01);
        drive(2'd0, 1'b0, 16'h0, 1'b0, 8'h0, 2'b00);
        step();

        // Reset after beat 2 of a 4-beat ch2 packet, with a beat parked in skid
        drive(2'd2, 1'b1, 16'h6201, 1'b0, 8'h62, 2'b11);
        step();
        chk("t6_grant2", 32'(grant_idx), 2);
        step();
        chk("t6_d0", 32'(m_tdata), 'h6201);
        drive(2'd2, 1'b1, 16'h6202, 1'b0, 8'h62, 2'b11);
        step();
        chk("t6_d1", 32'(m_tdata), 'h6202);
        drive(2'd2, 1'b1, 16'h6203, 1'b0, 8'h62, 2'b11);
        m_tready = 1'b0;
        step();
        chk("t6_hold_d", 32'(m_tdata), 'h6202);
        chk("t6_skid_full", 32'(s_tready), 0);
        areset = 1'b1;
        #1;
        chk("t6_rst_v", 32'(m_tvalid), 0);
        chk("t6_rst_d", 32'(m_tdata), 0);
        chk("t6_rst_l", 32'(m_tlast), 0);
        chk("t6_rst_id", 32'(m_tid), 0);
        chk("t6_rst_keep", 32'(m_tkeep), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_grant", 32'(grant_idx), 0);
        chk("t6_rst_rdy", 32'(s_tready), 0);
        drive(2'd2, 1'b1, 16'h6299, 1'b1, 8'h62, 2'b11);
        drive(2'd0, 1'b1, 16'h0F01, 1'b0, 8'h0F, 2'b11);
        m_tready = 1'b1;
        @(posedge aclk);
        #2;
        areset = 1'b0;
        step();
        chk("t6_grant0", 32'(grant_idx), 0);
        chk("t6_arb_v", 32'(m_tvalid), 0);
        step();
        chk("t6_d_new0", 32'(m_tdata), 'h0F01);
        chk("t6_l_new0", 32'(m_tlast), 0);
        drive(2'd0, 1'b1, 16'h0F02, 1'b1, 8'h0F, 2'b11);
        step();
        chk("t6_d_new1", 32'(m_tdata), 'h0F02);
        chk("t6_l_new1", 32'(m_tlast), 1);
        drive(2'd0, 1'b0, 16'h0, 1'b0, 8'h0, 2'b00);
        drive(2'd2, 1'b0, 16'h0, 1'b0, 8'h0, 2'b00);
        step();
        chk("t6_end_v", 32'(m_tvalid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
